// File: rtl/pll_reset_seq.sv
// pll_reset_seq: turns a PLL lock indication and a raw board reset button
// into a clean, registered, active-low reset for logic clocked by clk25.
// Both asynchronous inputs are synchronized. Reset is released only after
// lock has been held continuously for HOLD_CYCLES cycles.
// Optional feature macro: PLL_RESET_SEQ_LOSS_CNT_EN enables the saturating
// lock-loss counter. When it is undefined, loss_count is tied to zero.
module pll_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                  clk25,
  input  logic                  rst_n,
  input  logic                  locked_i,
  input  logic                  btn_rst_n,
  output logic                  sys_rst_n,
  output logic [1:0]            state_o,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    HOLD      = 2'b01,
    RUN       = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   locked_s;
  logic                   btn_s;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       hold_cnt;
  logic [CNT_W-1:0]       hold_cnt_next;
  logic                   loss_inc;

  // Synchronizer chains; both clear to 0 so the sequence always restarts
  // from "not locked / button pressed" after reset.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= '0;
      btn_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked_i};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_rst_n};
    end
  end

  assign locked_s = lock_sync[SYNC_STAGES-1];
  assign btn_s    = btn_sync[SYNC_STAGES-1];

  // State, hold counter and the output reset flop. sys_rst_n is loaded from
  // the next state so that it always equals (state == RUN).
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      hold_cnt  <= '0;
      sys_rst_n <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_cnt_next;
      sys_rst_n <= (state_next == RUN);
    end
  end

  // Next-state logic. The hold counter restarts whenever HOLD is left, so a
  // single captured lock glitch costs a full new hold window.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    loss_inc      = 1'b0;
    case (state)
      WAIT_LOCK: begin
        hold_cnt_next = '0;
        if (locked_s && btn_s) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!locked_s || !btn_s) begin
          state_next    = WAIT_LOCK;
          hold_cnt_next = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next    = RUN;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        hold_cnt_next = '0;
        if (!locked_s) begin
          // Lock loss is counted even when the button drops at the same time.
          state_next = WAIT_LOCK;
          loss_inc   = 1'b1;
        end else if (!btn_s) begin
          state_next = WAIT_LOCK;
        end
      end
      default: begin
        state_next    = WAIT_LOCK;
        hold_cnt_next = '0;
      end
    endcase
  end

  assign state_o = state;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + LOSS_CNT_W'(1);
  endfunction

  // Saturating count of lock losses observed in RUN.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (loss_inc) begin
      loss_q <= sat_inc(loss_q);
    end
  end

  assign loss_count = loss_q;
`else
  logic loss_inc_unused;
  assign loss_inc_unused = loss_inc;
  assign loss_count      = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with SYNC_STAGES=2, HOLD_CYCLES=16.
module tb_pll_reset_seq;

  localparam int SS = 2;
  localparam int HC = 16;
  localparam int LW = 8;
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  localparam logic [1:0] S_WAIT = 2'b00;
  localparam logic [1:0] S_HOLD = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;

  logic          clk25 = 1'b0;
  logic          rst_n = 1'b0;
  logic          locked_i = 1'b1;
  logic          btn_rst_n = 1'b1;
  logic          sys_rst_n;
  logic [1:0]    state_o;
  logic [LW-1:0] loss_count;

  always #5 clk25 = ~clk25;

  pll_reset_seq #(
    .SYNC_STAGES(SS),
    .HOLD_CYCLES(HC),
    .LOSS_CNT_W (LW)
  ) dut (
    .clk25     (clk25),
    .rst_n     (rst_n),
    .locked_i  (locked_i),
    .btn_rst_n (btn_rst_n),
    .sys_rst_n (sys_rst_n),
    .state_o   (state_o),
    .loss_count(loss_count)
  );

  typedef struct {
    int         phase;
    logic       lock;
    logic       btn;
    logic [1:0] st;
    logic       rst;
    int         loss;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input int ph, input int n, input logic lk, input logic bt,
                     input logic [1:0] st, input logic rs, input int ls);
    for (int i = 0; i < n; i++) vecs.push_back('{ph, lk, bt, st, rs, ls});
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_loss_of(input int v);
    return LOSS_EN ? v : 0;
  endfunction

  task automatic run_phase(input int ph);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == ph) begin
        locked_i  = vecs[i].lock;
        btn_rst_n = vecs[i].btn;
        tick();
        chk($sformatf("p%0d.v%0d.state", ph, i), 32'(state_o), 32'(vecs[i].st));
        chk($sformatf("p%0d.v%0d.sys_rst_n", ph, i), 32'(sys_rst_n), 32'(vecs[i].rst));
        chk($sformatf("p%0d.v%0d.loss", ph, i), 32'(loss_count), 32'(exp_loss_of(vecs[i].loss)));
      end
    end
  endtask

  task automatic wait_run(input int limit, input string name);
    int k = 0;
    while (sys_rst_n !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    chk(name, 32'(sys_rst_n), 32'd1);
  endtask

  initial begin
    int exp_loss;

    // Phase 0: power-up, lock and button stable from the start.
    add(0, 2,  1'b1, 1'b1, S_WAIT, 1'b0, 0);
    add(0, HC, 1'b1, 1'b1, S_HOLD, 1'b0, 0);
    add(0, 3,  1'b1, 1'b1, S_RUN,  1'b1, 0);
    // Phase 1: lock lost for 3 cycles in RUN, then relock.
    add(1, 2,  1'b0, 1'b1, S_RUN,  1'b1, 0);
    add(1, 1,  1'b0, 1'b1, S_WAIT, 1'b0, 1);
    add(1, 2,  1'b1, 1'b1, S_WAIT, 1'b0, 1);
    add(1, HC, 1'b1, 1'b1, S_HOLD, 1'b0, 1);
    add(1, 1,  1'b1, 1'b1, S_RUN,  1'b1, 1);
    // Phase 2: button pressed 4 cycles in RUN, lock held.
    add(2, 2,  1'b1, 1'b0, S_RUN,  1'b1, 1);
    add(2, 2,  1'b1, 1'b0, S_WAIT, 1'b0, 1);
    add(2, 2,  1'b1, 1'b1, S_WAIT, 1'b0, 1);
    add(2, HC, 1'b1, 1'b1, S_HOLD, 1'b0, 1);
    add(2, 2,  1'b1, 1'b1, S_RUN,  1'b1, 1);
    // Phase 3: after async reset, one-cycle lock glitch at hold count 10.
    add(3, 2,  1'b1, 1'b1, S_WAIT, 1'b0, 0);
    add(3, 11, 1'b1, 1'b1, S_HOLD, 1'b0, 0);
    add(3, 1,  1'b0, 1'b1, S_HOLD, 1'b0, 0);
    add(3, 1,  1'b1, 1'b1, S_HOLD, 1'b0, 0);
    add(3, 1,  1'b1, 1'b1, S_WAIT, 1'b0, 0);
    add(3, HC, 1'b1, 1'b1, S_HOLD, 1'b0, 0);
    add(3, 2,  1'b1, 1'b1, S_RUN,  1'b1, 0);

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rst.c%0d.state", i), 32'(state_o), 32'(S_WAIT));
      chk($sformatf("rst.c%0d.sys_rst_n", i), 32'(sys_rst_n), 32'd0);
      chk($sformatf("rst.c%0d.loss", i), 32'(loss_count), 32'd0);
    end
    #4 rst_n = 1'b1;

    run_phase(0);
    run_phase(1);
    run_phase(2);

    // Asynchronous reset pulse of half a cycle in RUN.
    @(posedge clk25);
    #1 rst_n = 1'b0;
    #2;
    chk("async.state", 32'(state_o), 32'(S_WAIT));
    chk("async.sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("async.loss", 32'(loss_count), 32'd0);
    #2 rst_n = 1'b1;

    run_phase(3);

    // 260 lock losses; first and last also drop the button the same cycle.
    exp_loss = 0;
    for (int i = 0; i < 260; i++) begin
      locked_i  = 1'b0;
      btn_rst_n = (i == 0 || i == 259) ? 1'b0 : 1'b1;
      repeat (3) tick();
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      chk($sformatf("sat.i%0d.sys_rst_n", i), 32'(sys_rst_n), 32'd0);
      chk($sformatf("sat.i%0d.loss", i), 32'(loss_count), 32'(exp_loss_of(exp_loss)));
      locked_i  = 1'b1;
      btn_rst_n = 1'b1;
      wait_run(40, $sformatf("sat.i%0d.relock", i));
    end
    chk("sat.final", 32'(loss_count), 32'(exp_loss_of(255)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each async input (legal 2..4).
REQ-002 SHALL have parameter HOLD_CYCLES, default 1024, consecutive synchronized-lock cycles required before reset release (legal 1..65535).
REQ-003 SHALL have parameter LOSS_CNT_W, default 8, width of the lock-loss counter.
REQ-004 SHALL have port clk25  input  1  system clock; the single clock of the block.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port locked_i  input  1  PLL lock indication, asynchronous to clk25.
REQ-007 SHALL have port btn_rst_n  input  1  board reset button, active-low, asynchronous, unfiltered.
REQ-008 SHALL have port sys_rst_n  output  1  registered active-low reset for downstream logic.
REQ-009 SHALL have port state_o  output  2  current FSM state (00 WAIT_LOCK, 01 HOLD, 10 RUN).
REQ-010 SHALL have port loss_count  output  LOSS_CNT_W  number of lock losses seen while in RUN.

Function
REQ-011 SHALL pass locked_i and btn_rst_n each through SYNC_STAGES flops; FSM uses only synchronized values locked_s, btn_s.
REQ-012 SHALL implement FSM with states WAIT_LOCK, HOLD, RUN; encoding 11 unused and SHALL transition to WAIT_LOCK if ever reached.
REQ-013 WAIT_LOCK: locked_s=1 and btn_s=1 -> HOLD with hold counter cleared to 0; otherwise stay.
REQ-014 HOLD: counter increments each cycle; locked_s=0 or btn_s=0 -> WAIT_LOCK, counter cleared; counter==HOLD_CYCLES-1 with locked_s=1, btn_s=1 -> RUN.
REQ-015 RUN: locked_s=0 -> WAIT_LOCK and loss_count increments; btn_s=0 (lock held) -> WAIT_LOCK without increment.
REQ-016 Simultaneous locked_s=0 and btn_s=0 in RUN -> WAIT_LOCK, loss_count increments (lock loss takes priority for counting).
REQ-017 loss_count SHALL saturate at all-ones; no wrap.
REQ-018 sys_rst_n SHALL be a flop, 1 exactly when registered state is RUN; assertion (fall) and release (rise) both synchronous to clk25.
REQ-019 Release latency: counting the first clk25 edge that samples locked_i=1 (button released, held stable) as edge 0, sys_rst_n SHALL rise after edge SYNC_STAGES+HOLD_CYCLES.
REQ-020 Lock-loss latency: sys_rst_n SHALL fall after edge SYNC_STAGES when locked_i drops at edge 0 in RUN.
REQ-021 Hold counter width SHALL be clog2(HOLD_CYCLES+1); counter SHALL never wrap.
REQ-022 A locked_i glitch shorter than one clk25 period in HOLD that is captured SHALL restart the full HOLD_CYCLES window.

Reset
REQ-023 rst_n low SHALL asynchronously force: all synchronizer flops 0, state WAIT_LOCK, hold counter 0, sys_rst_n 0, loss_count 0.
REQ-024 rst_n release SHALL NOT by itself release sys_rst_n; full lock-and-hold sequence SHALL be required.
REQ-025 rst_n asserted mid-HOLD or in RUN SHALL discard progress; loss_count SHALL clear.

Configuration
REQ-026 Macro PLL_RESET_SEQ_LOSS_CNT_EN defined: loss counter implemented per REQ-015..017.
REQ-027 Macro PLL_RESET_SEQ_LOSS_CNT_EN undefined: no counter flops; loss_count tied to 0; all other behaviour identical.

Verification (SYNC_STAGES=2, HOLD_CYCLES=16, LOSS_CNT_W=8, macro defined unless noted)
REQ-028 Power-up: rst_n low 5 cycles, locked_i=1, btn_rst_n=1 from start -> sys_rst_n rises after edge 18 counted from first edge after rst_n release; state_o 00->01->10.
REQ-029 Glitch in HOLD: locked_i low for 1 cycle at HOLD count 10 -> state_o returns 00, then full 16-cycle HOLD again; loss_count stays 0.
REQ-030 Lock loss in RUN: locked_i low 3 cycles -> sys_rst_n low after 2 edges, loss_count=1; relock -> sys_rst_n high 18 edges after relock sample.
REQ-031 Button in RUN: btn_rst_n low 4 cycles, locked_i=1 -> sys_rst_n low, loss_count unchanged; release -> full HOLD then RUN.
REQ-032 Saturation and simultaneity: 260 lock losses, last with btn_rst_n low same cycle -> loss_count=255; macro undefined -> loss_count=0 throughout.
REQ-033 Async reset mid-RUN: rst_n low for half a cycle -> sys_rst_n 0 immediately, loss_count 0, state_o 00.
